// File: rtl/pipeline_stage_skid.sv
// rtl/pipeline_stage_skid.sv - two-entry skid-buffered pipeline stage with stall counter
module pipeline_stage_skid #(
  parameter int PIX_W     = 9,
  parameter int INDEX_W   = 16,
  parameter int WIN_PIX   = 16,
  parameter int FRAME_PIX = 77
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       clr_stats,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_trigger,
  input  logic [INDEX_W-1:0]         in_index,
  input  logic [WIN_PIX*PIX_W-1:0]   in_window,
  input  logic [FRAME_PIX*PIX_W-1:0] in_frame,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_trigger,
  output logic [INDEX_W-1:0]         out_index,
  output logic [WIN_PIX*PIX_W-1:0]   out_window,
  output logic [FRAME_PIX*PIX_W-1:0] out_frame,
  output logic [15:0]                stall_cnt
);

  localparam int WIN_W = WIN_PIX * PIX_W;
  localparam int FRM_W = FRAME_PIX * PIX_W;
  localparam int PL_W  = 1 + INDEX_W + WIN_W + FRM_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PL_W-1:0] main_q, skid_q, in_pl;
  logic            in_xfer, out_xfer, stall;
  logic            load_main_in, load_main_skid, load_skid;

  // Whole payload travels as one vector so no field can drift from the others.
  assign in_pl = {in_trigger, in_index, in_window, in_frame};
  assign {out_trigger, out_index, out_window, out_frame} = main_q;

  // Handshake outputs come from the registered state only; out_ready never reaches in_ready.
  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign stall     = out_valid & ~out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  // Next state and payload-load selects; flush overrides every transfer.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_xfer) begin
            load_main_in = 1'b1;
            state_d      = S_ONE;
          end
        end
        S_ONE: begin
          if (in_xfer && out_xfer) begin
            load_main_in = 1'b1;
          end else if (in_xfer) begin
            load_skid = 1'b1;
            state_d   = S_TWO;
          end else if (out_xfer) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_ready) begin
            load_main_skid = 1'b1;
            state_d        = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Payload registers; flush leaves contents alone, only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_pl;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_pl;
    end
  end

  // Saturating count of cycles where a valid output is held off downstream.
  always_ff @(posedge clk) begin
    if (reset)                             stall_cnt <= '0;
    else if (clr_stats)                    stall_cnt <= '0;
    else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// tb/tb_pipeline_stage_skid.sv - randomized and directed checks of pipeline_stage_skid against a queue model
module tb_pipeline_stage_skid;

  localparam int PIX_W = 9, INDEX_W = 16, WIN_PIX = 16, FRAME_PIX = 77;
  localparam int WIN_W = WIN_PIX * PIX_W;
  localparam int FRM_W = FRAME_PIX * PIX_W;
  localparam int PL_W  = 1 + INDEX_W + WIN_W + FRM_W;

  localparam int P8 = 8, W8 = 64, F8 = 4;

  logic               clk = 1'b0;
  logic               reset, flush, clr_stats, in_valid, out_ready, in_trigger;
  logic [INDEX_W-1:0] in_index;
  logic [WIN_W-1:0]   in_window;
  logic [FRM_W-1:0]   in_frame;
  logic               in_ready, out_valid, out_trigger;
  logic [INDEX_W-1:0] out_index;
  logic [WIN_W-1:0]   out_window;
  logic [FRM_W-1:0]   out_frame;
  logic [15:0]        stall_cnt;

  logic               in_valid8, out_ready8, in_trigger8, in_ready8, out_valid8, out_trigger8;
  logic [15:0]        in_index8, out_index8, stall_cnt8;
  logic [W8*P8-1:0]   in_window8, out_window8;
  logic [F8*P8-1:0]   in_frame8, out_frame8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_stage_skid dut (
    .clk(clk), .reset(reset), .flush(flush), .clr_stats(clr_stats),
    .in_valid(in_valid), .in_ready(in_ready), .in_trigger(in_trigger),
    .in_index(in_index), .in_window(in_window), .in_frame(in_frame),
    .out_valid(out_valid), .out_ready(out_ready), .out_trigger(out_trigger),
    .out_index(out_index), .out_window(out_window), .out_frame(out_frame),
    .stall_cnt(stall_cnt)
  );

  pipeline_stage_skid #(.PIX_W(P8), .INDEX_W(16), .WIN_PIX(W8), .FRAME_PIX(F8)) dut8 (
    .clk(clk), .reset(reset), .flush(1'b0), .clr_stats(1'b0),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_trigger(in_trigger8),
    .in_index(in_index8), .in_window(in_window8), .in_frame(in_frame8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_trigger(out_trigger8),
    .out_index(out_index8), .out_window(out_window8), .out_frame(out_frame8),
    .stall_cnt(stall_cnt8)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [PL_W-1:0] act, input logic [PL_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference model: a FIFO of at most two payloads plus a saturating stall counter.
  logic [PL_W-1:0] mq[$];
  logic [15:0]     mcnt = '0;
  bit              mlive = 1'b0;

  always @(posedge clk) begin : model
    int  sz;
    bit  in_x, out_x;
    if (reset) begin
      mq.delete();
      mcnt  = '0;
      mlive = 1'b1;
    end else if (mlive) begin
      sz    = mq.size();
      in_x  = in_valid && (sz < 2);
      out_x = (sz > 0) && out_ready;
      if (clr_stats) mcnt = '0;
      else if (sz > 0 && !out_ready && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      if (flush) begin
        mq.delete();
      end else begin
        if (out_x) void'(mq.pop_front());
        if (in_x)  mq.push_back({in_trigger, in_index, in_window, in_frame});
      end
    end
  end

  // Cycle-by-cycle comparison of the default-parameter DUT with the model.
  always @(negedge clk) begin
    if (mlive) begin
      chk1("in_ready", in_ready, mq.size() < 2);
      chk1("out_valid", out_valid, mq.size() > 0);
      chk16("stall_cnt", stall_cnt, mcnt);
      if (mq.size() > 0)
        chkw("payload", {out_trigger, out_index, out_window, out_frame}, mq[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PL_W-1:0] rand_pl();
    logic [PL_W-1:0] v;
    for (int i = 0; i < PL_W; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic set_pl(input logic [PL_W-1:0] p);
    {in_trigger, in_index, in_window, in_frame} = p;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; clr_stats = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_pl('0);
    in_valid8 = 1'b0; out_ready8 = 1'b1; in_trigger8 = 1'b0; in_index8 = '0;
    in_window8 = '0; in_frame8 = '0;
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk16("rst_stall", stall_cnt, 16'h0000);
    chk16("rst_out_index", out_index, 16'h0000);
    chk1("rst8_in_ready", in_ready8, 1'b1);

    // Back-to-back streaming, one-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_pl(rand_pl());
      in_index = 16'(i);
      in_valid = 1'b1;
      tick();
      chk1("stream_valid", out_valid, 1'b1);
      chk16("stream_index", out_index, 16'(i));
      chk1("stream_ready", in_ready, 1'b1);
    end
    chk16("stream_stall", stall_cnt, 16'h0000);
    idle(2);

    // Skid fill and drain
    in_valid = 1'b1; in_index = 16'd5; out_ready = 1'b1;
    tick();
    in_index = 16'd6; out_ready = 1'b0;
    tick();
    chk16("skid_idx_a", out_index, 16'd5);
    chk1("skid_ready_a", in_ready, 1'b0);
    chk16("skid_stall_a", stall_cnt, 16'd1);
    in_index = 16'd7;
    tick();
    chk16("skid_idx_b", out_index, 16'd5);
    chk1("skid_ready_b", in_ready, 1'b0);
    chk16("skid_stall_b", stall_cnt, 16'd2);
    out_ready = 1'b1;
    tick();
    chk16("skid_out6", out_index, 16'd6);
    tick();
    chk16("skid_out7", out_index, 16'd7);
    in_valid = 1'b0;
    tick();
    chk1("skid_empty", out_valid, 1'b0);
    chk16("skid_stall_end", stall_cnt, 16'd2);

    // Flush in TWO with a simultaneous input
    in_valid = 1'b1; out_ready = 1'b0; in_index = 16'h0011;
    tick();
    in_index = 16'h0022;
    tick();
    chk1("pre_flush_full", in_ready, 1'b0);
    chk16("pre_flush_stall", stall_cnt, 16'd3);
    flush = 1'b1; out_ready = 1'b1; in_index = 16'hBEEF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk1("flush_out_valid", out_valid, 1'b0);
    chk1("flush_in_ready", in_ready, 1'b1);
    chk16("flush_stall", stall_cnt, 16'd3);
    tick();
    chk1("flush_no_ghost", out_valid, 1'b0);
    idle(3);

    // Saturation then clear with a simultaneous stall
    in_valid = 1'b1; out_ready = 1'b1; set_pl(rand_pl());
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (70000) tick();
    chk16("sat_stall", stall_cnt, 16'hFFFF);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk16("clr_stall", stall_cnt, 16'h0000);
    tick();
    chk16("clr_then_inc", stall_cnt, 16'h0001);
    idle(2);

    // Reset in TWO
    in_valid = 1'b1; out_ready = 1'b0; set_pl(rand_pl());
    tick();
    set_pl(rand_pl());
    tick();
    chk1("pre_rst_full", in_ready, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    chk1("mid_rst_valid", out_valid, 1'b0);
    chk1("mid_rst_ready", in_ready, 1'b1);
    chk16("mid_rst_stall", stall_cnt, 16'h0000);
    chkw("mid_rst_payload", {out_trigger, out_index, out_window, out_frame}, '0);

    // Payload integrity, PIX_W=9
    for (int k = 0; k < WIN_PIX; k++)   in_window[k*PIX_W +: PIX_W] = PIX_W'(k + 256);
    for (int k = 0; k < FRAME_PIX; k++) in_frame[k*PIX_W +: PIX_W]  = PIX_W'(511 - k);
    in_trigger = 1'b1; in_index = 16'hA5A5; in_valid = 1'b1; out_ready = 1'b1;
    in_index8 = 16'h5A5A; in_trigger8 = 1'b1; in_valid8 = 1'b1;
    for (int k = 0; k < W8; k++) in_window8[k*P8 +: P8] = P8'(k + 256);
    for (int k = 0; k < F8; k++) in_frame8[k*P8 +: P8]  = P8'(511 - k);
    tick();
    in_valid = 1'b0; in_valid8 = 1'b0;
    chk1("int_trigger", out_trigger, 1'b1);
    chk16("int_index", out_index, 16'hA5A5);
    for (int k = 0; k < WIN_PIX; k++)
      chk16("int_win9", 16'(out_window[k*PIX_W +: PIX_W]), 16'(k + 256));
    for (int k = 0; k < FRAME_PIX; k++)
      chk16("int_frm9", 16'(out_frame[k*PIX_W +: PIX_W]), 16'(511 - k));
    chk1("int8_valid", out_valid8, 1'b1);
    chk1("int8_trigger", out_trigger8, 1'b1);
    chk16("int8_index", out_index8, 16'h5A5A);
    for (int k = 0; k < W8; k++)
      chk16("int_win8", 16'(out_window8[k*P8 +: P8]), 16'(k));
    for (int k = 0; k < F8; k++)
      chk16("int_frm8", 16'(out_frame8[k*P8 +: P8]), 16'(255 - k));
    tick();
    chk1("int8_drain", out_valid8, 1'b0);
    chk1("int8_ready", in_ready8, 1'b1);
    chk16("int8_stall", stall_cnt8, 16'h0000);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      clr_stats = ($urandom_range(0, 63) == 0);
      reset     = ($urandom_range(0, 255) == 0);
      set_pl(rand_pl());
      tick();
    end
    reset = 1'b0; flush = 1'b0; clr_stats = 1'b0; in_valid = 1'b0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
